memory_stage: RTL and testbench
===============================

// Module: memory_stage
// PURPOSE
//  RV32 pipeline MEM stage, directly downstream of the execute stage. Consumes the E->M
//  register outputs, performs the data-memory load/store, and registers the M->W bundle
//  for writeback. An optional wait-state FSM models multi-cycle memory and raises a stall.
// PARAMETERS
//  DEPTH    64  data-memory depth in 32-bit words; power of two, >=4
//  MEM_LAT  1   access latency in cycles; used only with MEM_WAIT_EN; >=1
// PORTS
//  clk          in   1   clock; all state updates on posedge
//  rst          in   1   synchronous reset, active-high
//  regwriteM    in   1   instruction writes the register file
//  memwriteM    in   1   store
//  resultsrcM   in   1   1 = load (writeback selects read data); 0 = ALU result
//  aluresultM   in   32  ALU result; also the byte address for loads/stores
//  writedataM   in   32  store data (forwarded rs2)
//  RDM          in   5   destination register
//  pcincr4M     in   32  PC+4
//  regwriteW    out  1   registered regwriteM (0 while stalled)
//  resultsrcW   out  1   registered resultsrcM
//  readdataW    out  32  registered load data
//  aluresultW   out  32  registered aluresultM
//  RDW          out  5   registered RDM
//  pcincr4W     out  32  registered pcincr4M
//  stallM       out  1   comb.; 1 = access not yet complete, hazard unit freezes F/D/E/M
// BEHAVIOUR
//  - Reset (rst=1 at posedge): every W output <= 0; FSM -> IDLE; wait counter <= 0.
//    Memory array is not cleared. stallM is 0 in the cycle after reset.
//  - Address: word index = aluresultM[log2(DEPTH)+1:2]. Bits [1:0] ignored (no misalign
//    trap). Upper bits truncated, so addresses wrap modulo DEPTH*4.
//  - Read: combinational from the array, captured into readdataW at the posedge. Load data
//    is visible on readdataW one cycle after the load is presented (1-cycle latency).
//  - Write: synchronous, on a posedge where memwriteM=1 and the access completes.
//    Read-during-write to the same word in the same cycle returns OLD data.
//  - Access = memwriteM | resultsrcM. Non-access instructions never stall.
//  - M->W register: on a completing (non-stalled) cycle, captures all inputs and read data.
//    On a stalled cycle it loads a bubble: regwriteW=0, other W fields unchanged.
// CONFIGURATION
//  - MEM_WAIT_EN undefined: stallM tied 0; every access completes in its first cycle;
//    MEM_LAT ignored; no FSM logic instantiated.
//  - MEM_WAIT_EN defined: FSM {IDLE, WAIT} with counter cnt (width clog2(MEM_LAT)+1).
//      IDLE: access & MEM_LAT>1 -> stallM=1, cnt<=1, ->WAIT; otherwise complete here.
//      WAIT: cnt<MEM_LAT-1 -> stallM=1, cnt<=cnt+1; cnt==MEM_LAT-1 -> stallM=0,
//      access completes (store commits, W captures), cnt<=0, ->IDLE.
//      Result: MEM_LAT-1 stall cycles, completion in cycle MEM_LAT. MEM_LAT=1 is equivalent
//      to the macro being off. Upstream must hold all M inputs stable while stallM=1.
//      Reset in WAIT aborts the access: no store commit, IDLE, stallM=0.
// STRUCTURE
//  - Package riscv_pipe_pkg: XLEN=32, REG_ADDR_W=5, mem_state_t enum {IDLE, WAIT}.
//  - Sub-module data_mem (DEPTH): word array, comb. read port, sync write port with we.
//  - memory_stage: address slicing, optional wait FSM, M->W pipeline register.
// TESTING
//  1 rst=1 for 2 cycles with random inputs -> all W outputs 0, stallM 0.
//  2 store 0xDEADBEEF @0x10, next cycle load @0x10 RDM=5 -> readdataW=0xDEADBEEF,
//    regwriteW=1, RDW=5, resultsrcW=1 one cycle after the load.
//  3 ALU op aluresultM=0x1234, RDM=7, regwriteM=1, resultsrcM=0 -> aluresultW=0x1234,
//    RDW=7, resultsrcW=0 next cycle; memory unchanged.
//  4 DEPTH=64: store 0xA5A5A5A5 @0x100, load @0x000 -> readdataW=0xA5A5A5A5 (wrap);
//    load @0x013 returns word @0x010 (low bits ignored).
//  5 MEM_WAIT_EN, MEM_LAT=3: load held 3 cycles -> stallM=1,1,0; regwriteW=0 after the two
//    stalled cycles; data + regwriteW=1 after the third.
//  6 MEM_WAIT_EN, MEM_LAT=3: store 0x1 @0x20, rst=1 on 2nd cycle -> stallM=0 after reset,
//    later load @0x20 returns prior contents (store not committed).

Source files
------------

// File: rtl/riscv_pipe_pkg.sv
// Shared definitions for the RV32 pipeline stages: datapath widths and the
// state type of the memory-stage wait-state controller.
package riscv_pipe_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  // IDLE: ready for a new access; WAIT: a multi-cycle access is in flight.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

endpackage

// File: rtl/memory_stage_data_mem.sv
// Data memory for the MEM stage: DEPTH x 32-bit word array with a
// combinational read port and a synchronous write port. The array has no
// reset, so contents survive a pipeline reset. A read of the word being
// written in the same cycle returns the old contents.
module data_mem
  import riscv_pipe_pkg::*;
#(
  parameter int  DEPTH = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            we_i,
  input  logic [AW-1:0]   addr_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic [XLEN-1:0] rdata_o
);

  logic [XLEN-1:0] mem_q [DEPTH];

  // Commit a store to the addressed word at the clock edge.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/memory_stage.sv
// RV32 MEM stage: data-memory load/store plus the M->W pipeline register.
// Optional feature macro MEM_WAIT_EN: when defined, a wait-state controller
// stretches each memory access to MEM_LAT cycles and raises stallM for the
// first MEM_LAT-1 of them. When undefined, every access completes in one
// cycle and stallM is tied low.
module memory_stage
  import riscv_pipe_pkg::*;
#(
  parameter int DEPTH   = 64,
  parameter int MEM_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  regwriteM,
  input  logic                  memwriteM,
  input  logic                  resultsrcM,
  input  logic [XLEN-1:0]       aluresultM,
  input  logic [XLEN-1:0]       writedataM,
  input  logic [REG_ADDR_W-1:0] RDM,
  input  logic [XLEN-1:0]       pcincr4M,
  output logic                  regwriteW,
  output logic                  resultsrcW,
  output logic [XLEN-1:0]       readdataW,
  output logic [XLEN-1:0]       aluresultW,
  output logic [REG_ADDR_W-1:0] RDW,
  output logic [XLEN-1:0]       pcincr4W,
  output logic                  stallM
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]   word_idx_s;
  logic [XLEN-1:0] rdata_s;
  logic            access_s;
  logic            stall_s;
  logic            we_s;

  // Byte address -> word index; low two bits and bits above the array wrap.
  assign word_idx_s = aluresultM[AW+1:2];
  assign access_s   = memwriteM | resultsrcM;

  logic unused_addr_bits_s;
  assign unused_addr_bits_s = ^{aluresultM[XLEN-1:AW+2], aluresultM[1:0]};

`ifdef MEM_WAIT_EN
  localparam int              CW          = $clog2(MEM_LAT) + 1;
  localparam logic [CW-1:0]   LAT_M1      = CW'(MEM_LAT - 1);
  localparam logic            MULTI_CYCLE = (MEM_LAT > 1);

  mem_state_t    state_q;
  logic [CW-1:0] cnt_q;

  // Stall while the access has not yet reached its final cycle.
  always_comb begin
    stall_s = 1'b0;
    case (state_q)
      IDLE:    stall_s = access_s & MULTI_CYCLE;
      WAIT:    stall_s = (cnt_q < LAT_M1);
      default: stall_s = 1'b0;
    endcase
  end

  // Wait-state controller: count cycles of a multi-cycle access; reset aborts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= {CW{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          if (access_s && MULTI_CYCLE) begin
            state_q <= WAIT;
            cnt_q   <= CW'(1);
          end else begin
            state_q <= IDLE;
            cnt_q   <= {CW{1'b0}};
          end
        end
        WAIT: begin
          if (cnt_q >= LAT_M1) begin
            state_q <= IDLE;
            cnt_q   <= {CW{1'b0}};
          end else begin
            state_q <= WAIT;
            cnt_q   <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= {CW{1'b0}};
        end
      endcase
    end
  end
`else
  localparam int unused_mem_lat = MEM_LAT;

  assign stall_s = 1'b0;
`endif

  assign stallM = stall_s;

  // A store commits only on its completing cycle and never while in reset.
  assign we_s = memwriteM & ~stall_s & ~rst;

  data_mem #(
    .DEPTH (DEPTH)
  ) u_data_mem (
    .clk     (clk),
    .we_i    (we_s),
    .addr_i  (word_idx_s),
    .wdata_i (writedataM),
    .rdata_o (rdata_s)
  );

  logic                  regwrite_q,   regwrite_d;
  logic                  resultsrc_q,  resultsrc_d;
  logic [XLEN-1:0]       readdata_q,   readdata_d;
  logic [XLEN-1:0]       aluresult_q,  aluresult_d;
  logic [REG_ADDR_W-1:0] rd_q,         rd_d;
  logic [XLEN-1:0]       pcincr4_q,    pcincr4_d;

  // M->W next state: capture on completion, inject a bubble while stalled.
  always_comb begin
    regwrite_d  = regwrite_q;
    resultsrc_d = resultsrc_q;
    readdata_d  = readdata_q;
    aluresult_d = aluresult_q;
    rd_d        = rd_q;
    pcincr4_d   = pcincr4_q;
    if (stall_s) begin
      regwrite_d = 1'b0;
    end else begin
      regwrite_d  = regwriteM;
      resultsrc_d = resultsrcM;
      readdata_d  = rdata_s;
      aluresult_d = aluresultM;
      rd_d        = RDM;
      pcincr4_d   = pcincr4M;
    end
  end

  // M->W pipeline register with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      regwrite_q  <= 1'b0;
      resultsrc_q <= 1'b0;
      readdata_q  <= {XLEN{1'b0}};
      aluresult_q <= {XLEN{1'b0}};
      rd_q        <= {REG_ADDR_W{1'b0}};
      pcincr4_q   <= {XLEN{1'b0}};
    end else begin
      regwrite_q  <= regwrite_d;
      resultsrc_q <= resultsrc_d;
      readdata_q  <= readdata_d;
      aluresult_q <= aluresult_d;
      rd_q        <= rd_d;
      pcincr4_q   <= pcincr4_d;
    end
  end

  assign regwriteW  = regwrite_q;
  assign resultsrcW = resultsrc_q;
  assign readdataW  = readdata_q;
  assign aluresultW = aluresult_q;
  assign RDW        = rd_q;
  assign pcincr4W   = pcincr4_q;

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage. A transaction-level model (word
// array plus expected W register) predicts every output; access latency is
// MEM_LAT cycles when MEM_WAIT_EN is defined, otherwise one cycle.
module tb_memory_stage;

  localparam int DEPTH  = 64;
  localparam int TB_LAT = 3;
`ifdef MEM_WAIT_EN
  localparam int L = TB_LAT;
`else
  localparam int L = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        regwriteM, memwriteM, resultsrcM;
  logic [31:0] aluresultM, writedataM, pcincr4M;
  logic [4:0]  RDM;
  logic        regwriteW, resultsrcW, stallM;
  logic [31:0] readdataW, aluresultW, pcincr4W;
  logic [4:0]  RDW;

  memory_stage #(.DEPTH(DEPTH), .MEM_LAT(TB_LAT)) dut (
    .clk(clk), .rst(rst),
    .regwriteM(regwriteM), .memwriteM(memwriteM), .resultsrcM(resultsrcM),
    .aluresultM(aluresultM), .writedataM(writedataM), .RDM(RDM), .pcincr4M(pcincr4M),
    .regwriteW(regwriteW), .resultsrcW(resultsrcW), .readdataW(readdataW),
    .aluresultW(aluresultW), .RDW(RDW), .pcincr4W(pcincr4W), .stallM(stallM)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state
  logic [31:0] mem_m [DEPTH];
  logic        e_rw, e_rs;
  logic [31:0] e_rd_data, e_alu, e_pc;
  logic [4:0]  e_rd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int widx(input logic [31:0] addr);
    return int'((addr / 32'd4) % DEPTH);
  endfunction

  task automatic check_w(input string tag);
    check({tag, ".regwriteW"},  {31'd0, regwriteW},  {31'd0, e_rw});
    check({tag, ".resultsrcW"}, {31'd0, resultsrcW}, {31'd0, e_rs});
    check({tag, ".readdataW"},  readdataW,  e_rd_data);
    check({tag, ".aluresultW"}, aluresultW, e_alu);
    check({tag, ".RDW"},        {27'd0, RDW}, {27'd0, e_rd});
    check({tag, ".pcincr4W"},   pcincr4W,   e_pc);
  endtask

  task automatic model_reset();
    e_rw = 1'b0; e_rs = 1'b0; e_rd_data = 32'd0; e_alu = 32'd0; e_rd = 5'd0; e_pc = 32'd0;
  endtask

  task automatic drive(input logic rw, input logic mw, input logic rs, input logic [31:0] alu,
                       input logic [31:0] wd, input logic [4:0] rd, input logic [31:0] pc);
    regwriteM = rw; memwriteM = mw; resultsrcM = rs;
    aluresultM = alu; writedataM = wd; RDM = rd; pcincr4M = pc;
  endtask

  // Present one instruction, holding it for the whole access, checking every cycle.
  task automatic run_instr(input string tag, input logic rw, input logic mw, input logic rs,
                           input logic [31:0] alu, input logic [31:0] wd,
                           input logic [4:0] rd, input logic [31:0] pc);
    int n;
    n = (mw | rs) ? L : 1;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      drive(rw, mw, rs, alu, wd, rd, pc);
      #1;
      check({tag, ".stallM"}, {31'd0, stallM}, (c < n - 1) ? 32'd1 : 32'd0);
      @(posedge clk);
      #1;
      if (c < n - 1) begin
        e_rw = 1'b0;
      end else begin
        e_rw = rw; e_rs = rs; e_alu = alu; e_rd = rd; e_pc = pc;
        e_rd_data = mem_m[widx(alu)];
        if (mw) mem_m[widx(alu)] = wd;
      end
      check_w(tag);
    end
  endtask

  initial begin
    logic [31:0] r, old20;
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 32'd0);
    model_reset();

    // 1: reset with random inputs
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive(1'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom, 5'($urandom), $urandom);
      @(posedge clk);
      #1;
      check_w("reset");
    end
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 32'd0);
    #1;
    check("reset.stallM", {31'd0, stallM}, 32'd0);

    // Give every word a known value
    for (int i = 0; i < DEPTH; i++) begin
      r = $urandom;
      run_instr("init", 1'b0, 1'b1, 1'b0, 32'(i * 4), r, 5'd0, 32'(i * 4 + 4));
    end

    // 2: store then load
    run_instr("st10", 1'b0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 5'd0, 32'h104);
    run_instr("ld10", 1'b1, 1'b0, 1'b1, 32'h10, 32'h0, 5'd5, 32'h108);
    check("ld10.data", readdataW, 32'hDEADBEEF);
    check("ld10.rw",   {31'd0, regwriteW}, 32'd1);
    check("ld10.rd",   {27'd0, RDW}, 32'd5);
    check("ld10.rs",   {31'd0, resultsrcW}, 32'd1);

    // 3: ALU op, memory untouched
    run_instr("alu", 1'b1, 1'b0, 1'b0, 32'h1234, 32'hFFFF_FFFF, 5'd7, 32'h10C);
    check("alu.result", aluresultW, 32'h1234);
    check("alu.rd",     {27'd0, RDW}, 32'd7);
    run_instr("ld1234", 1'b1, 1'b0, 1'b1, 32'h1234, 32'h0, 5'd8, 32'h110);

    // 4: wrap and ignored low bits
    run_instr("st100", 1'b0, 1'b1, 1'b0, 32'h100, 32'hA5A5A5A5, 5'd0, 32'h114);
    run_instr("ld000", 1'b1, 1'b0, 1'b1, 32'h000, 32'h0, 5'd9, 32'h118);
    check("wrap.data", readdataW, 32'hA5A5A5A5);
    run_instr("ld013", 1'b1, 1'b0, 1'b1, 32'h013, 32'h0, 5'd10, 32'h11C);
    check("lowbits.data", readdataW, 32'hDEADBEEF);

    // 5/6: store aborted by reset on its second cycle
    old20 = mem_m[widx(32'h20)];
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 32'h20, 32'h1, 5'd0, 32'h120);
    #1;
    check("abort.stall1", {31'd0, stallM}, (L > 1) ? 32'd1 : 32'd0);
    @(posedge clk);
    #1;
    if (L == 1) begin
      e_rw = 1'b0; e_rs = 1'b0; e_alu = 32'h20; e_rd = 5'd0; e_pc = 32'h120;
      e_rd_data = mem_m[widx(32'h20)];
      mem_m[widx(32'h20)] = 32'h1;
    end else begin
      e_rw = 1'b0;
    end
    check_w("abort.c1");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    check_w("abort.rst");
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 32'd0);
    #1;
    check("abort.stallM", {31'd0, stallM}, 32'd0);
    run_instr("ld20", 1'b1, 1'b0, 1'b1, 32'h20, 32'h0, 5'd11, 32'h124);
    check("abort.data", readdataW, (L > 1) ? old20 : 32'h1);

    // Random mix of loads, stores and ALU ops
    for (int i = 0; i < 80; i++) begin
      int kind;
      kind = int'($urandom_range(0, 2));
      run_instr("rand", 1'($urandom), kind == 1, kind == 2, $urandom, $urandom,
                5'($urandom), $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
